// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for an 8-digit common-anode
// seven-segment display. It latches a 32-bit word from the bus decoder and
// scans one hex nibble per digit, with optional leading-zero blanking.
//
// Ports:
//   clk          system clock
//   rstn         synchronous active-low reset
//   seg7_we      write strobe, loads cpuseg7_data
//   cpuseg7_data word to display
//   blank_en     leading-zero blanking enable (sampled every edge)
//   disp_an_o    active-low one-hot digit anodes, bit 0 = rightmost digit
//   disp_seg_o   active-low segments, bit0=a .. bit6=g, bit7=dp (always off)
//   seg7_data_o  currently latched display word
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        seg7_we,
  input  logic [31:0] cpuseg7_data,
  input  logic        blank_en,
  output logic [7:0]  disp_an_o,
  output logic [7:0]  disp_seg_o,
  output logic [31:0] seg7_data_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [31:0]      r_data;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;

  logic [2:0]       w_hi;
  logic [3:0]       w_nib;
  logic [7:0]       w_seg;

  // Hex nibble to active-high gfedcba pattern.
  function automatic logic [6:0] f_decode(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h3F;
      4'h1: c = 7'h06;
      4'h2: c = 7'h5B;
      4'h3: c = 7'h4F;
      4'h4: c = 7'h66;
      4'h5: c = 7'h6D;
      4'h6: c = 7'h7D;
      4'h7: c = 7'h07;
      4'h8: c = 7'h7F;
      4'h9: c = 7'h6F;
      4'hA: c = 7'h77;
      4'hB: c = 7'h7C;
      4'hC: c = 7'h39;
      4'hD: c = 7'h5E;
      4'hE: c = 7'h79;
      default: c = 7'h71;
    endcase
    return c;
  endfunction

  // Index of the highest nonzero nibble; stays 0 for an all-zero word so
  // digit 0 is never blanked.
  always_comb begin
    w_hi = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_data[4*i +: 4] != 4'd0) w_hi = 3'(i);
    end
  end

  // Segment pattern for the digit currently selected by r_idx.
  always_comb begin
    w_nib = r_data[{r_idx, 2'b00} +: 4];
    if (blank_en && (r_idx > w_hi)) w_seg = 8'hFF;
    else                            w_seg = ~{1'b0, f_decode(w_nib)};
  end

  // Data latch, scan divider/digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data <= 32'd0;
      r_div  <= '0;
      r_idx  <= 3'd0;
      r_an   <= 8'hFF;
      r_seg  <= 8'hFF;
    end else begin
      if (seg7_we) r_data <= cpuseg7_data;
      if (r_div == DIV_W'(SCAN_DIV - 1)) begin
        r_div <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= w_seg;
    end
  end

  assign disp_an_o   = r_an;
  assign disp_seg_o  = r_seg;
  assign seg7_data_o = r_data;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        seg7_we;
  logic [31:0] cpuseg7_data;
  logic        blank_en;
  logic [7:0]  disp_an_o;
  logic [7:0]  disp_seg_o;
  logic [31:0] seg7_data_o;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;        // posedges since the first edge with rstn high
  logic [15:0] sb_q[$];  // expected {an, seg}

  seg7_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rstn(rstn), .seg7_we(seg7_we), .cpuseg7_data(cpuseg7_data),
    .blank_en(blank_en), .disp_an_o(disp_an_o), .disp_seg_o(disp_seg_o),
    .seg7_data_o(seg7_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] ref_seg(input logic [31:0] w, input int d, input logic bl);
    int h = 0;
    for (int i = 0; i < 8; i++) if (w[4*i +: 4] != 4'd0) h = i;
    if (bl && d > h) return 8'hFF;
    return ~{1'b0, ref_code(w[4*d +: 4])};
  endfunction

  function automatic logic [7:0] ref_an(input int d);
    logic [7:0] one = 8'b1;
    return ~(one << d);
  endfunction

  task automatic step();
    @(negedge clk);
    edge_n++;
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) step();
  endtask

  // Reset for one edge, check reset values, release; returns after edge 1.
  task automatic do_reset(input bit chk);
    rstn = 1'b0;
    @(negedge clk);
    if (chk) begin
      n_cmp++;
      if (disp_an_o !== 8'hFF) begin n_bad++; $display("FAIL reset_an: got %h want ff", disp_an_o); end
      n_cmp++;
      if (disp_seg_o !== 8'hFF) begin n_bad++; $display("FAIL reset_seg: got %h want ff", disp_seg_o); end
      n_cmp++;
      if (seg7_data_o !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", seg7_data_o); end
    end
    rstn = 1'b1;
    edge_n = 0;
    step();
  endtask

  task automatic pop_check(input string name);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({disp_an_o, disp_seg_o} !== e)
        begin n_bad++; $display("FAIL %s @edge %0d: got an=%h seg=%h want an=%h seg=%h",
                                name, edge_n, disp_an_o, disp_seg_o, e[15:8], e[7:0]); end
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    // After edge k the anode shows digit (k-1)/DIV mod 8.
    for (int k = 1; k <= 36; k++) sb_q.push_back({ref_an(((k - 1) / DIV) % 8), 8'hC0});
    for (int k = 1; k <= 36; k++) begin
      step_to(k);
      pop_check("scan_seq");
    end
  endtask

  task automatic test_full_scan();
    do_reset(1'b0);
    blank_en = 1'b0;
    seg7_we = 1'b1; cpuseg7_data = 32'h89ABCDEF;
    for (int d = 0; d < 8; d++) sb_q.push_back({ref_an(d), ref_seg(32'h89ABCDEF, d, 1'b0)});
    step();
    seg7_we = 1'b0;
    n_cmp++;
    if (seg7_data_o !== 32'h89ABCDEF) begin n_bad++; $display("FAIL write_data: got %h want 89abcdef", seg7_data_o); end
    for (int d = 0; d < 8; d++) begin
      step_to(DIV * d + 3);
      pop_check("full_scan");
    end
  endtask

  task automatic test_blanking();
    do_reset(1'b0);
    blank_en = 1'b1;
    seg7_we = 1'b1; cpuseg7_data = 32'h00000120;
    for (int d = 0; d < 8; d++) sb_q.push_back({ref_an(d), ref_seg(32'h00000120, d, 1'b1)});
    step();
    seg7_we = 1'b0;
    for (int d = 0; d < 8; d++) begin
      step_to(DIV * d + 3);
      pop_check("blank_120");
    end
    // Write 0 near the end of the first scan; second scan checks it.
    seg7_we = 1'b1; cpuseg7_data = 32'd0;
    for (int d = 0; d < 8; d++) sb_q.push_back({ref_an(d), ref_seg(32'd0, d, 1'b1)});
    step();
    seg7_we = 1'b0;
    for (int d = 0; d < 8; d++) begin
      step_to(DIV * (d + 8) + 3);
      pop_check("blank_zero");
    end
    // blank_en dropped mid-slot becomes visible after one edge.
    step_to(DIV * 19 + 2);  // digit 3 slot, data 0
    blank_en = 1'b0;
    sb_q.push_back({ref_an(3), 8'hC0});
    step();
    pop_check("blank_toggle");
  endtask

  task automatic test_write_on_advance();
    do_reset(1'b0);
    blank_en = 1'b0;
    step_to(DIV - 1);
    // Sampled on edge DIV, which is also the idx 0->1 advance edge.
    seg7_we = 1'b1; cpuseg7_data = 32'h00000050;
    sb_q.push_back({ref_an(0), 8'hC0});
    sb_q.push_back({ref_an(1), ref_seg(32'h00000050, 1, 1'b0)});
    step();
    seg7_we = 1'b0;
    pop_check("adv_old_digit");
    step();
    pop_check("adv_new_digit");
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    blank_en = 1'b0;
    seg7_we = 1'b1; cpuseg7_data = 32'hFFFFFFFF;
    step();
    seg7_we = 1'b0;
    step_to(DIV * 5 + 2);  // idx = 5
    n_cmp++;
    if (disp_an_o !== 8'hDF) begin n_bad++; $display("FAIL pre_reset_an: got %h want df", disp_an_o); end
    rstn = 1'b0; seg7_we = 1'b1; cpuseg7_data = 32'h12345678;
    @(negedge clk);
    seg7_we = 1'b0;
    n_cmp++;
    if ({disp_an_o, disp_seg_o} !== 16'hFFFF) begin n_bad++; $display("FAIL midrst_out: got %h%h want ffff", disp_an_o, disp_seg_o); end
    n_cmp++;
    if (seg7_data_o !== 32'd0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", seg7_data_o); end
    rstn = 1'b1;
    edge_n = 0;
    sb_q.push_back({8'hFE, 8'hC0});
    sb_q.push_back({8'hFD, 8'hC0});
    step();
    pop_check("midrst_restart");
    step_to(DIV + 1);
    pop_check("midrst_digit1");
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    blank_en = 1'b0;
    seg7_we = 1'b1; cpuseg7_data = 32'h11111111;
    step();
    cpuseg7_data = 32'h22222222;
    step();
    seg7_we = 1'b0;
    n_cmp++;
    if (seg7_data_o !== 32'h22222222) begin n_bad++; $display("FAIL b2b_data: got %h want 22222222", seg7_data_o); end
    for (int d = 0; d < 8; d++) sb_q.push_back({ref_an(d), 8'hA4});
    for (int d = 0; d < 8; d++) begin
      step_to(DIV * d + 4);
      pop_check("b2b_scan");
    end
  endtask

  initial begin
    rstn = 1'b0; seg7_we = 1'b0; cpuseg7_data = 32'd0; blank_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_scan();
    test_blanking();
    test_write_on_advance();
    test_mid_reset();
    test_back_to_back();
    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
